// File: rtl/period_meter.sv
// period_meter: measures the period of an asynchronous input in clk cycles.
// sig_in is synchronized, the clk cycles between two consecutive rising edges
// after a start request are counted, and the result is returned through a
// valid/ready handshake. A non-zero timeout bounds the cycles from start to
// completion; with timeout == 0 the counters saturate instead of wrapping.
// Optional feature macro: PERIOD_METER_HIGH_TIME_EN adds the high_time output.
module period_meter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] timeout,
  output logic                 busy,
  output logic                 valid,
  input  logic                 ready,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 timed_out
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [CNT_WIDTH-1:0] high_time
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE1,
    MEASURE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 timed_out_q, timed_out_d;

  logic                 rise;
  logic [CNT_WIDTH-1:0] elapsed_inc;
  logic                 timeout_hit, elapsed_sat, count_sat;
  logic                 enter_meas, meas_step;
  logic                 fin_meas, fin_to, fin_sat;

  assign rise        = sync2_q & ~prev_q;
  assign elapsed_inc = elapsed_q + CNT_WIDTH'(1);
  assign timeout_hit = (timeout != '0) && (elapsed_inc == timeout);
  assign elapsed_sat = (timeout == '0) && (elapsed_q == '1);
  assign count_sat   = (timeout == '0) && (count_q == '1);

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign period    = period_q;
  assign timed_out = timed_out_q;

  // Two-flop synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state logic; completion, timeout and saturation are flagged separately
  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    enter_meas = 1'b0;
    meas_step  = 1'b0;
    fin_meas   = 1'b0;
    fin_to     = 1'b0;
    fin_sat    = 1'b0;
    case (state_q)
      IDLE: begin
        elapsed_d = '0;
        if (start) state_d = WAIT_EDGE1;
      end
      WAIT_EDGE1: begin
        // timeout must beat a first edge here, otherwise elapsed would pass
        // the timeout value and the measurement could never terminate
        if (timeout_hit) fin_to = 1'b1;
        else if (elapsed_sat) fin_sat = 1'b1;
        else begin
          elapsed_d = elapsed_inc;
          if (rise) begin
            state_d    = MEASURE;
            enter_meas = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (rise && !count_sat) fin_meas = 1'b1;
        else if (timeout_hit) fin_to = 1'b1;
        else if (elapsed_sat || count_sat) fin_sat = 1'b1;
        else begin
          elapsed_d = elapsed_inc;
          meas_step = 1'b1;
        end
      end
      DONE: begin
        if (ready) begin
          if (start) begin
            state_d   = WAIT_EDGE1;
            elapsed_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin_meas || fin_to || fin_sat) state_d = DONE;
  end

  // Period counter, result registers and registered status decode
  always_comb begin
    count_d     = count_q;
    period_d    = period_q;
    timed_out_d = timed_out_q;
    if (enter_meas) count_d = '0;
    else if (meas_step) count_d = count_q + CNT_WIDTH'(1);
    if (fin_meas) begin
      period_d    = count_q + CNT_WIDTH'(1);
      timed_out_d = 1'b0;
    end else if (fin_to) begin
      period_d    = '0;
      timed_out_d = 1'b1;
    end else if (fin_sat) begin
      period_d    = '1;
      timed_out_d = 1'b1;
    end
    busy_d  = (state_d == WAIT_EDGE1) || (state_d == MEASURE);
    valid_d = (state_d == DONE);
  end

  // State, counter and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      elapsed_q   <= '0;
      count_q     <= '0;
      period_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      elapsed_q   <= elapsed_d;
      count_q     <= count_d;
      period_q    <= period_d;
      timed_out_q <= timed_out_d;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;

  assign high_time = high_time_q;

  // High-time counter: the first-edge cycle counts, so it starts at 1
  always_comb begin
    high_d      = high_q;
    high_time_d = high_time_q;
    if (enter_meas) high_d = CNT_WIDTH'(1);
    else if (meas_step) high_d = high_q + CNT_WIDTH'(sync2_q);
    if (fin_meas) high_time_d = high_q;
    else if (fin_to) high_time_d = '0;
    else if (fin_sat) high_time_d = '1;
  end

  // High-time registers
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q      <= '0;
      high_time_q <= '0;
    end else begin
      high_q      <= high_d;
      high_time_q <= high_time_d;
    end
  end
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter.
module tb_period_meter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in;
  logic         start;
  logic         ready;
  logic [W-1:0] timeout;
  logic         busy;
  logic         valid;
  logic [W-1:0] period;
  logic         timed_out;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [W-1:0] high_time;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // square-wave generator state, advanced by step()
  bit gen_en = 1'b0;
  int gen_hi = 1;
  int gen_lo = 1;
  int gen_phase = 0;

  always #5 clk = ~clk;

  period_meter #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .start     (start),
    .timeout   (timeout),
    .busy      (busy),
    .valid     (valid),
    .ready     (ready),
    .period    (period),
    .timed_out (timed_out)
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    .high_time (high_time)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (gen_en) begin
      gen_phase = (gen_phase + 1) % (gen_hi + gen_lo);
      sig_in = (gen_phase < gen_hi);
    end
  endtask

  task automatic gen_start(input int hi, input int lo);
    gen_hi = hi;
    gen_lo = lo;
    gen_phase = 0;
    sig_in = 1'b1;
    gen_en = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (!valid && cycles < max_cycles) begin
      step();
      cycles++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic accept();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ready = 1'b0; timeout = '0; sig_in = 1'b0;
    repeat (3) step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL reset_period got=%0d exp=0", period); end
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL reset_timed_out got=%0b exp=0", timed_out); end
`ifdef PERIOD_METER_HIGH_TIME_EN
    n_tests++; if (high_time !== '0) begin n_fail++; $display("FAIL reset_high_time got=%0d exp=0", high_time); end
`endif
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_div4();
    int n;
    gen_start(2, 2);
    pulse_start();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div4_busy got=%0b exp=1", busy); end
    wait_valid(100, n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL div4_valid_wait got=%0b exp=1 after %0d cycles", valid, n); end
    n_tests++; if (period !== 32'd4) begin n_fail++; $display("FAIL div4_period got=%0d exp=4", period); end
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL div4_timed_out got=%0b exp=0", timed_out); end
`ifdef PERIOD_METER_HIGH_TIME_EN
    n_tests++; if (high_time !== 32'd2) begin n_fail++; $display("FAIL div4_high_time got=%0d exp=2", high_time); end
`endif
    accept();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL div4_valid_drop got=%0b exp=0", valid); end
  endtask

  task automatic test_div7();
    int n;
    gen_start(3, 4);
    for (int rep = 0; rep < 2; rep++) begin
      pulse_start();
      wait_valid(100, n);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL div7_valid_wait rep=%0d got=%0b exp=1", rep, valid); end
      n_tests++; if (period !== 32'd7) begin n_fail++; $display("FAIL div7_period rep=%0d got=%0d exp=7", rep, period); end
      n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL div7_timed_out rep=%0d got=%0b exp=0", rep, timed_out); end
`ifdef PERIOD_METER_HIGH_TIME_EN
      n_tests++; if (high_time !== 32'd3) begin n_fail++; $display("FAIL div7_high_time rep=%0d got=%0d exp=3", rep, high_time); end
`endif
      accept();
    end
  endtask

  task automatic test_timeout();
    int n;
    gen_en = 1'b0;
    sig_in = 1'b0;
    repeat (4) step();
    timeout = 32'd100;
    pulse_start();
    wait_valid(150, n);
    n_tests++; if (n !== 100) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=100", n); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL timeout_valid got=%0b exp=1", valid); end
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL timeout_period got=%0d exp=0", period); end
    n_tests++; if (timed_out !== 1'b1) begin n_fail++; $display("FAIL timeout_timed_out got=%0b exp=1", timed_out); end
`ifdef PERIOD_METER_HIGH_TIME_EN
    n_tests++; if (high_time !== '0) begin n_fail++; $display("FAIL timeout_high_time got=%0d exp=0", high_time); end
`endif
    accept();
    timeout = '0;
  endtask

  task automatic test_back_to_back();
    int n;
    gen_start(2, 2);
    pulse_start();
    step();
    pulse_start();  // arrives while busy, must be dropped
    wait_valid(100, n);
    n_tests++; if (period !== 32'd4) begin n_fail++; $display("FAIL bp_period got=%0d exp=4", period); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", i, valid); end
      n_tests++; if (period !== 32'd4) begin n_fail++; $display("FAIL bp_hold_period cyc=%0d got=%0d exp=4", i, period); end
    end
    accept();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_queued_start got=%0b exp=0", busy); end
    pulse_start();
    wait_valid(100, n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got=%0b exp=1", valid); end
    ready = 1'b1;
    start = 1'b1;
    step();
    ready = 1'b0;
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop got=%0b exp=0", valid); end
    wait_valid(100, n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got=%0b exp=1", valid); end
    n_tests++; if (period !== 32'd4) begin n_fail++; $display("FAIL b2b_second_period got=%0d exp=4", period); end
    accept();
  endtask

  task automatic test_reset_mid();
    int n;
    gen_start(3, 4);
    pulse_start();
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%0b exp=0", valid); end
    n_tests++; if (period !== '0) begin n_fail++; $display("FAIL rstmid_period got=%0d exp=0", period); end
    repeat (8) step();
    pulse_start();
    wait_valid(100, n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_wait got=%0b exp=1", valid); end
    n_tests++; if (period !== 32'd7) begin n_fail++; $display("FAIL rstmid_period_after got=%0d exp=7", period); end
    accept();
  endtask

  task automatic test_edge_and_timeout();
    int j;
    gen_en = 1'b0;
    sig_in = 1'b0;
    repeat (4) step();
    // first rise is seen at elapsed 2, second at elapsed 12 -> timeout 13
    timeout = 32'd13;
    pulse_start();
    j = 0;
    while (!valid && j < 40) begin
      sig_in = (j < 5) || (j >= 10 && j < 15);
      step();
      j++;
    end
    n_tests++; if (j !== 13) begin n_fail++; $display("FAIL simul_latency got=%0d exp=13", j); end
    n_tests++; if (period !== 32'd10) begin n_fail++; $display("FAIL simul_period got=%0d exp=10", period); end
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL simul_timed_out got=%0b exp=0", timed_out); end
`ifdef PERIOD_METER_HIGH_TIME_EN
    n_tests++; if (high_time !== 32'd5) begin n_fail++; $display("FAIL simul_high_time got=%0d exp=5", high_time); end
`endif
    accept();
    timeout = '0;
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div7();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_edge_and_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of a slow, asynchronous digital signal (e.g. a divided clock from the frequency divider, an external tachometer or a button-derived pulse train) in units of `clk` cycles. The block synchronizes `sig_in`, counts `clk` cycles between two consecutive rising edges after a `start` request, and returns the result through a valid/ready output handshake with a programmable timeout. It sits beside the clock-generation blocks as their checking and measurement counterpart, feeding results to the display and control logic.

## Interface
- `CNT_WIDTH`, default 32: width of the period, timeout and internal counters.
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `sig_in`  input  1  asynchronous signal to be measured.
- `start`  input  1  pulse that requests one measurement.
- `timeout`  input  CNT_WIDTH  maximum number of cycles allowed from start to completion; 0 disables the timeout.
- `busy`  output  1  high while a measurement is in progress (WAIT_EDGE1 or MEASURE).
- `valid`  output  1  result available; held until it is accepted.
- `ready`  input  1  the consumer accepts the result when `valid && ready`.
- `period`  output  CNT_WIDTH  measured period in `clk` cycles; 0 on timeout.
- `timed_out`  output  1  result is a timeout or saturation, not a measurement.
- `high_time`  output  CNT_WIDTH  present only with the macro in Configuration.

## Operation
- **Input path.** Two-flop synchronizer on `sig_in`, followed by a registered previous-value flop.
  - `rise = sync & ~prev`.
  - All three flops reset to 0.
- **States.** IDLE, WAIT_EDGE1, MEASURE, DONE.
- **IDLE:**
  - `start` moves to WAIT_EDGE1.
  - `elapsed` is cleared to 0.
  - `rise` is ignored.
- **WAIT_EDGE1:**
  - `elapsed` increments each cycle.
  - `rise` moves to MEASURE and clears `count` to 0.
- **MEASURE:**
  - `count` and `elapsed` increment each cycle.
  - On `rise`: `period <= count + 1`, `timed_out <= 0`, and the state moves to DONE.
- **Timeout.** In WAIT_EDGE1 or MEASURE with `timeout != 0` and `elapsed + 1 == timeout` with no completing `rise`, the block enters DONE with `period = 0` and `timed_out = 1`. If the completing `rise` and the timeout condition occur in the same cycle, the measurement wins.
- **Saturation.** When `timeout == 0` and `count` or `elapsed` would wrap past all-ones, the block enters DONE with `period` set to all-ones and `timed_out = 1`. Counters never wrap.
- **DONE:**
  - `valid = 1`; `period`, `timed_out` and `high_time` are held stable.
  - `valid && ready` returns the state to IDLE.
  - If `start` is also high in that same cycle, the state goes directly to WAIT_EDGE1 with `elapsed` cleared.
- **`start` outside IDLE/DONE.** A `start` pulse in WAIT_EDGE1 or MEASURE is ignored. It is not queued.
- **`busy`** is a registered decode of the state: 1 in WAIT_EDGE1 and MEASURE.

## Timing
- **Reset values.** State IDLE; `busy = 0`, `valid = 0`, `period = 0`, `timed_out = 0`, `high_time = 0`; all counters 0.
- **Reset priority.** Reset overrides everything, mid-measurement included. There is no partial result.
- **Input latency.** A `sig_in` transition appears on `rise` 3 cycles later. This latency is constant, so it cancels out of `period`.
- **Start to busy.** `busy` rises the cycle after `start` is accepted.
- **Completion to valid.** `valid` rises the cycle after the completing `rise` or the timeout cycle.
- **Timeout latency.** A timeout result has `valid` high exactly `timeout` cycles after the `start` cycle.
- **Handshake.** Results never change while `valid = 1`; `valid` falls the cycle after acceptance.
- **Spurious post-reset edge.** A `sig_in` held high through reset produces one `rise` about 3 cycles after reset is released. It is discarded unless the block is in WAIT_EDGE1, where it counts as the first edge.
- **Minimum measurable period.** 2 cycles. The synchronizer cannot resolve anything faster.

## Configuration
- Macro: `PERIOD_METER_HIGH_TIME_EN`.
- **Defined.** `high_time` output exists.
  - In MEASURE, a high counter increments on every cycle where `sync = 1`, including the first-edge cycle.
  - It latches to `high_time` together with `period`.
  - It is 0 on timeout and saturates with the period counter.
- **Undefined.** The port and the counter are absent; all other behaviour is identical.

## Test plan
- **Divide by 4.** `sig_in` from a divide-by-4 divider (2 cycles high, 2 low), `start` -> `period = 4`, `timed_out = 0`, `high_time = 2`.
- **Divide by 7.** `sig_in` from a divide-by-7 divider (3 cycles high, 4 low) -> `period = 7`, `high_time = 3`; a repeat measurement gives the same values.
- **Timeout.** `sig_in` held at 0, `timeout = 100`, `start` at cycle T -> `valid` at T+100, `period = 0`, `timed_out = 1`.
- **Backpressure and back-to-back.** Hold `ready = 0` for 20 cycles after `valid` -> outputs stable and `start` ignored while busy. Then assert `ready` and `start` in the same cycle -> `busy` the next cycle, and a second result arrives correctly.
- **Reset mid-measurement.** Assert `reset` while in MEASURE -> next cycle shows `busy = 0`, `valid = 0`, `period = 0`. A new `start` then measures normally.
- **Simultaneous edge and timeout.** `period = 10` with `timeout` chosen so the second edge lands on the timeout cycle -> `period = 10`, `timed_out = 0`.
